// File: rtl/board_reset_ctrl.sv
// Board-level reset sequencer: waits for stable PLL lock, stretches reset, and
// debounces front-panel buttons, one of which can force a system reset.
module board_reset_ctrl #(
  parameter int                  NUM_LOCKS          = 2,
  parameter int                  NUM_BTNS           = 7,
  parameter logic [NUM_BTNS-1:0] BTN_ACTIVE_LOW     = 7'b0000001,
  parameter int                  RESET_BTN          = 0,
  parameter int                  DEBOUNCE_CYCLES    = 500_000,
  parameter int                  LOCK_STABLE_CYCLES = 256,
  parameter int                  HOLD_CYCLES        = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_LOCKS-1:0] locked_i,
  input  logic [NUM_BTNS-1:0]  btn_i,
  output logic                 sys_reset_o,
  output logic [NUM_BTNS-1:0]  btn_o,
  output logic [NUM_BTNS-1:0]  btn_press_o,
  output logic [NUM_BTNS-1:0]  btn_release_o,
  output logic [2:0]           state_o,
  output logic [7:0]           reset_count_o
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    HOLD        = 3'd2,
    RUN         = 3'd3,
    BTN_HELD    = 3'd4
  } state_t;

  logic [NUM_LOCKS-1:0] lock_s1, lock_s2;
  logic [NUM_BTNS-1:0]  btn_s1, btn_s2;
  logic [NUM_BTNS-1:0]  btn_norm;
  logic [NUM_BTNS-1:0]  btn_prev;
  logic [DB_W-1:0]      db_cnt [NUM_BTNS];
  logic                 lock_all;
  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
    end else begin
      lock_s1 <= locked_i;
      lock_s2 <= lock_s1;
      btn_s1  <= btn_i;
      btn_s2  <= btn_s1;
    end
  end

  assign btn_norm = btn_s2 ^ BTN_ACTIVE_LOW;
  assign lock_all = &lock_s2;

  // A level is accepted after DEBOUNCE_CYCLES consecutive cycles disagreeing with btn_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_o <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        if (btn_norm[i] == btn_o[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_o[i]  <= ~btn_o[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_prev      <= '0;
      btn_press_o   <= '0;
      btn_release_o <= '0;
    end else begin
      btn_prev      <= btn_o;
      btn_press_o   <= btn_o & ~btn_prev;
      btn_release_o <= ~btn_o & btn_prev;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_all) state_next = LOCK_STABLE;
      end
      LOCK_STABLE: begin
        if (!lock_all) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_all) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_all)                state_next = WAIT_LOCK;
        else if (btn_o[RESET_BTN])    state_next = BTN_HELD;
      end
      BTN_HELD: begin
        cnt_next = '0;
        if (!lock_all)                state_next = WAIT_LOCK;
        else if (!btn_o[RESET_BTN])   state_next = HOLD;
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // sys_reset_o tracks next_state so it changes on the same edge as entering/leaving RUN.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      sys_reset_o   <= 1'b1;
      reset_count_o <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      sys_reset_o <= (state_next != RUN);
      if (state == RUN && state_next != RUN && reset_count_o != 8'hFF)
        reset_count_o <= reset_count_o + 8'd1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Scoreboard bench for board_reset_ctrl: expectations are queued with the edge
// at which they must hold and compared on the following falling edge.
module tb_board_reset_ctrl;

  localparam int S_SYS   = 0;
  localparam int S_STATE = 1;
  localparam int S_CNT   = 2;
  localparam int S_BTN   = 3;
  localparam int S_B1    = 4;
  localparam int S_P1    = 5;
  localparam int S_R1    = 6;
  localparam int S_PCNT  = 7;
  localparam int S_B0    = 8;
  localparam int S_PRESS = 9;
  localparam int S_REL   = 10;

  typedef struct {
    string       tag;
    int          at_cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] locked;
  logic [6:0] btn;
  logic       sys_reset;
  logic [6:0] btn_lvl;
  logic [6:0] btn_press;
  logic [6:0] btn_release;
  logic [2:0] state;
  logic [7:0] reset_count;

  exp_t q[$];
  int   edge_n    = 0;
  int   press_cnt = 0;
  int   n_cmp     = 0;
  int   n_bad     = 0;

  board_reset_ctrl #(
    .NUM_LOCKS          (2),
    .NUM_BTNS           (7),
    .BTN_ACTIVE_LOW     (7'b0000001),
    .RESET_BTN          (0),
    .DEBOUNCE_CYCLES    (4),
    .LOCK_STABLE_CYCLES (4),
    .HOLD_CYCLES        (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .locked_i      (locked),
    .btn_i         (btn),
    .sys_reset_o   (sys_reset),
    .btn_o         (btn_lvl),
    .btn_press_o   (btn_press),
    .btn_release_o (btn_release),
    .state_o       (state),
    .reset_count_o (reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_SYS:   return 32'(sys_reset);
      S_STATE: return 32'(state);
      S_CNT:   return 32'(reset_count);
      S_BTN:   return 32'(btn_lvl);
      S_B1:    return 32'(btn_lvl[1]);
      S_P1:    return 32'(btn_press[1]);
      S_R1:    return 32'(btn_release[1]);
      S_PCNT:  return 32'(press_cnt);
      S_B0:    return 32'(btn_lvl[0]);
      S_PRESS: return 32'(btn_press);
      S_REL:   return 32'(btn_release);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void sb_push(input int at, input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.tag = tag; e.at_cyc = at; e.sel = sel; e.val = val;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (btn_press[1] === 1'b1) press_cnt++;
    while (q.size() > 0 && q[0].at_cyc <= edge_n) begin
      e = q.pop_front();
      if (e.at_cyc < edge_n) check({e.tag, "_missed"}, edge_n, e.at_cyc);
      else                   check(e.tag, sample(e.sel), e.val);
    end
  end

  task automatic wait_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_reset_values(input int at, input string pfx);
    sb_push(at, S_SYS,   1, {pfx, "_sys"});
    sb_push(at, S_STATE, 0, {pfx, "_state"});
    sb_push(at, S_CNT,   0, {pfx, "_cnt"});
    sb_push(at, S_BTN,   0, {pfx, "_btn"});
    sb_push(at, S_PRESS, 0, {pfx, "_press"});
    sb_push(at, S_REL,   0, {pfx, "_rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    rst    = 1'b1;
    locked = 2'b11;
    btn    = 7'b0000001;

    // power-up
    wait_to(3);
    e = edge_n;
    push_reset_values(e, "rst");
    sb_push(e + 2,  S_STATE, 0, "pu_sync");
    sb_push(e + 3,  S_STATE, 1, "pu_stable");
    sb_push(e + 7,  S_STATE, 2, "pu_hold");
    sb_push(e + 14, S_SYS,   1, "pu_sys_pre");
    sb_push(e + 15, S_SYS,   0, "pu_sys_rel");
    sb_push(e + 15, S_STATE, 3, "pu_run");
    sb_push(e + 15, S_CNT,   0, "pu_cnt");
    rst = 1'b0;
    wait_to(e + 16);

    // lock glitch during LOCK_STABLE
    e = edge_n;
    rst = 1'b1;
    wait_to(e + 1);
    rst = 1'b0;
    e = edge_n;
    sb_push(e + 6,  S_STATE, 1, "gl_stable");
    sb_push(e + 7,  S_STATE, 0, "gl_wait");
    sb_push(e + 8,  S_STATE, 1, "gl_relock");
    sb_push(e + 11, S_STATE, 1, "gl_stable_end");
    sb_push(e + 12, S_STATE, 2, "gl_hold");
    sb_push(e + 19, S_SYS,   1, "gl_sys_pre");
    sb_push(e + 20, S_SYS,   0, "gl_sys_rel");
    sb_push(e + 20, S_STATE, 3, "gl_run");
    wait_to(e + 4);
    locked[1] = 1'b0;
    wait_to(e + 5);
    locked[1] = 1'b1;
    wait_to(e + 20);

    // bounce: 3 cycles rejected
    e = edge_n;
    sb_push(e + 4,  S_B1,   0, "bn3_lvl_a");
    sb_push(e + 6,  S_B1,   0, "bn3_lvl_b");
    sb_push(e + 8,  S_B1,   0, "bn3_lvl_c");
    sb_push(e + 10, S_PCNT, 0, "bn3_press");
    btn[1] = 1'b1;
    wait_to(e + 3);
    btn[1] = 1'b0;
    wait_to(e + 10);

    // 6 cycles accepted, one press and one release pulse
    e = edge_n;
    sb_push(e + 5,  S_B1,    0, "bn6_lvl_pre");
    sb_push(e + 6,  S_B1,    1, "bn6_lvl");
    sb_push(e + 6,  S_P1,    0, "bn6_p_pre");
    sb_push(e + 7,  S_P1,    1, "bn6_p");
    sb_push(e + 8,  S_P1,    0, "bn6_p_post");
    sb_push(e + 11, S_B1,    1, "bn6_lvl_hold");
    sb_push(e + 12, S_B1,    0, "bn6_lvl_rel");
    sb_push(e + 13, S_R1,    1, "bn6_r");
    sb_push(e + 14, S_R1,    0, "bn6_r_post");
    sb_push(e + 16, S_PCNT,  1, "bn6_press_cnt");
    sb_push(e + 16, S_SYS,   0, "bn6_sys");
    sb_push(e + 16, S_STATE, 3, "bn6_state");
    btn[1] = 1'b1;
    wait_to(e + 6);
    btn[1] = 1'b0;
    wait_to(e + 17);

    // reset button (active-low pin 0)
    e = edge_n;
    sb_push(e + 6,  S_SYS,   0, "rb_sys_pre");
    sb_push(e + 6,  S_STATE, 3, "rb_run");
    sb_push(e + 6,  S_B0,    1, "rb_lvl");
    sb_push(e + 7,  S_SYS,   1, "rb_sys");
    sb_push(e + 7,  S_STATE, 4, "rb_held");
    sb_push(e + 7,  S_CNT,   1, "rb_cnt");
    sb_push(e + 12, S_STATE, 4, "rb_held_mid");
    sb_push(e + 18, S_STATE, 4, "rb_held_end");
    sb_push(e + 18, S_SYS,   1, "rb_sys_held");
    sb_push(e + 19, S_STATE, 2, "rb_hold");
    sb_push(e + 26, S_SYS,   1, "rb_hold_end");
    sb_push(e + 27, S_SYS,   0, "rb_sys_rel");
    sb_push(e + 27, S_STATE, 3, "rb_run_again");
    sb_push(e + 27, S_CNT,   1, "rb_cnt_final");
    btn[0] = 1'b0;
    wait_to(e + 12);
    btn[0] = 1'b1;
    wait_to(e + 28);

    // lock loss in RUN, then async reset mid-HOLD
    e = edge_n;
    sb_push(e + 2,  S_SYS,   0, "ll_sys_pre");
    sb_push(e + 3,  S_SYS,   1, "ll_sys");
    sb_push(e + 3,  S_STATE, 0, "ll_state");
    sb_push(e + 3,  S_CNT,   2, "ll_cnt");
    sb_push(e + 12, S_STATE, 2, "ll_hold");
    sb_push(e + 12, S_SYS,   1, "ll_hold_sys");
    locked[0] = 1'b0;
    wait_to(e + 4);
    locked[0] = 1'b1;
    wait_to(e + 13);
    rst = 1'b1;
    push_reset_values(edge_n, "arst");
    wait_to(edge_n + 2);
    rst = 1'b0;
    wait_to(edge_n + 4);

    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_reset_ctrl.md
BOARD_RESET_CTRL -- requirements
Module: board_reset_ctrl

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 2, number of PLL lock inputs combined.
REQ-002 SHALL have parameter NUM_BTNS, default 7, number of conditioned buttons.
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 7'b0000001, per-bit mask; a 1 means that button is active-low.
REQ-004 SHALL have parameter RESET_BTN, default 0, index of the button that forces system reset.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, stable-cycle count required before a button level is accepted; legal range >=1.
REQ-006 SHALL have parameter LOCK_STABLE_CYCLES, default 256, cycles all locks must stay high; legal range >=1.
REQ-007 SHALL have parameter HOLD_CYCLES, default 1024, reset stretch after qualification; legal range >=1.
REQ-008 SHALL have port clk_i, input, 1, sole clock.
REQ-009 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port locked_i, input, NUM_LOCKS, asynchronous PLL lock flags.
REQ-011 SHALL have port btn_i, input, NUM_BTNS, raw asynchronous button pins.
REQ-012 SHALL have port sys_reset_o, output, 1, registered active-high system reset.
REQ-013 SHALL have port btn_o, output, NUM_BTNS, debounced levels normalised so that 1 means pressed.
REQ-014 SHALL have port btn_press_o, output, NUM_BTNS, one-cycle pulse on each debounced 0->1 transition.
REQ-015 SHALL have port btn_release_o, output, NUM_BTNS, one-cycle pulse on each debounced 1->0 transition.
REQ-016 SHALL have port state_o, output, 3, current FSM state code.
REQ-017 SHALL have port reset_count_o, output, 8, saturating count of run-time resets.

Function
REQ-018 SHALL pass locked_i and btn_i each through a 2-flop synchroniser before any use.
REQ-019 SHALL compute the normalised button as synchronised btn_i XOR BTN_ACTIVE_LOW.
REQ-020 SHALL keep one debounce counter per button, each $clog2(DEBOUNCE_CYCLES+1) bits wide: cleared when the normalised input equals btn_o; otherwise incremented; at DEBOUNCE_CYCLES-1, btn_o toggles and the counter clears.
REQ-021 SHALL derive btn_press_o and btn_release_o from the registered btn_o edge, asserting them in the cycle after btn_o changes and holding them for exactly one cycle.
REQ-022 SHALL define lock_all as the AND of all synchronised lock bits.
REQ-023 SHALL implement FSM states WAIT_LOCK=0, LOCK_STABLE=1, HOLD=2, RUN=3, BTN_HELD=4, sharing one cycle counter sized for max(LOCK_STABLE_CYCLES, HOLD_CYCLES).
REQ-024 SHALL, in WAIT_LOCK, go to LOCK_STABLE with counter=0 when lock_all=1.
REQ-025 SHALL, in LOCK_STABLE, go to WAIT_LOCK if lock_all=0; otherwise go to HOLD with counter=0 when counter==LOCK_STABLE_CYCLES-1; otherwise increment the counter.
REQ-026 SHALL, in HOLD, go to WAIT_LOCK if lock_all=0, else go to RUN when counter==HOLD_CYCLES-1.
REQ-027 SHALL, in RUN, go to WAIT_LOCK on lock_all=0; otherwise go to BTN_HELD when btn_o[RESET_BTN]=1. Lock loss SHALL win when both occur in the same cycle.
REQ-028 SHALL, in BTN_HELD, go to HOLD with counter=0 when btn_o[RESET_BTN]=0, and go to WAIT_LOCK on lock_all=0.
REQ-029 SHALL register sys_reset_o as (next_state != RUN), so it deasserts on the edge that enters RUN and asserts on the edge that leaves RUN.
REQ-030 SHALL increment reset_count_o on every exit from RUN, saturating at 255.
REQ-031 SHALL ignore btn_o[RESET_BTN] in every state except RUN and BTN_HELD.

Reset
REQ-032 SHALL, while reset_i=1, immediately force: state=WAIT_LOCK, counters=0, synchronisers=0, sys_reset_o=1, btn_o=0, press/release pulses=0, reset_count_o=0.
REQ-033 SHALL honour reset_i asserted mid-sequence, in any state, with identical results.
REQ-034 SHALL release from reset_i synchronously: the first state change occurs on the first rising edge after reset_i falls.

Verification
Common parameters for all scenarios: LOCK_STABLE_CYCLES=4, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4, NUM_LOCKS=2.
REQ-035 SHALL cover power-up: locks=2'b11 throughout, release reset_i -> sys_reset_o falls on rising edge 15 (3+4+8), state_o=3, reset_count_o=0.
REQ-036 SHALL cover a lock glitch: locked_i[1] low for 1 cycle during LOCK_STABLE -> state_o returns to 0, and the full 4+8 count restarts after relock.
REQ-037 SHALL cover bounce rejection: a normalised button high for 3 cycles, then low -> btn_o stays 0 and no btn_press_o pulse; high for 6 cycles -> exactly one btn_press_o pulse.
REQ-038 SHALL cover a reset button press: in RUN, press btn[0] (drive 0) -> sys_reset_o=1 after sync plus debounce; it stays 1 while held; after the debounced release, 8 HOLD cycles follow, then 0; reset_count_o=1.
REQ-039 SHALL cover lock loss in RUN: drop locked_i[0] -> sys_reset_o=1 within 3 edges, state_o=0, reset_count_o increments.
REQ-040 SHALL cover asynchronous reset mid-HOLD: assert reset_i between clock edges -> all outputs show their REQ-032 values before the next edge.
